arp_request: RTL

//  ARP initiator and the request-side counterpart of the ARP responder path in mac.
//  On a request for an IPv4 address it streams a 28-byte ARP request payload to mac_encode
//  (broadcast, ethertype 0x0806), then waits for the matching reply from arp_decode.
//  It returns the resolved MAC, or an error after the retries run out.

---
 rtl/arp_request.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/arp_request.sv
// ARP request initiator.
// Streams a 28-byte ARP request payload to the Ethernet encoder (broadcast,
// ethertype 0x0806), waits for the matching reply and returns the resolved
// MAC address, retransmitting on timeout until the retry budget is spent.
// Optional feature: define ARP_CACHE_EN to add a single-entry resolution
// cache that answers repeated requests without sending a frame.
module arp_request #(
    parameter logic [47:0] MAC_ADDR       = 48'hDEADBEEFCAFE,
    parameter logic [31:0] IP_ADDR        = 32'h69696969,
    parameter int unsigned TIMEOUT_CYCLES = 12_500_000,
    parameter int unsigned MAX_RETRIES    = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [31:0] req_ip,
    output logic        req_ready,
    output logic        res_valid,
    output logic [47:0] res_mac,
    output logic        res_err,
    output logic        busy,
    output logic        tx_en,
    input  logic        tx_next,
    output logic        tx_ovalid,
    output logic [7:0]  tx_dout,
    output logic [47:0] tx_dest,
    output logic [15:0] tx_ethertype,
    input  logic        rx_done,
    input  logic [47:0] rx_sha,
    input  logic [31:0] rx_spa,
    input  logic [31:0] rx_tpa
);

    localparam int TIMER_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int RETRY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX  = RETRY_W'(MAX_RETRIES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT
    } state_t;

    state_t               state_q;
    logic [31:0]          target_q;
    logic [TIMER_W-1:0]   timer_q;
    logic [RETRY_W-1:0]   retry_q;
    logic [4:0]           idx_q;
    logic                 tx_en_q;
    logic                 res_valid_q;
    logic                 res_err_q;
    logic [47:0]          res_mac_q;

    logic [7:0]           payload_byte;
    logic                 tx_accept;
    logic                 rx_match;
    logic                 timer_expired;
    logic                 cache_hit;
    logic [47:0]          cache_mac;

    assign tx_dest      = 48'hFFFFFFFFFFFF;
    assign tx_ethertype = 16'h0806;

    assign req_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign tx_ovalid = (state_q == ST_SEND);
    assign tx_dout   = (state_q == ST_SEND) ? payload_byte : 8'h00;
    assign tx_en     = tx_en_q;
    assign res_valid = res_valid_q;
    assign res_err   = res_err_q;
    assign res_mac   = res_mac_q;

    assign tx_accept     = tx_next && tx_ovalid;
    assign rx_match      = rx_done && (rx_spa == target_q) && (rx_tpa == IP_ADDR);
    assign timer_expired = (timer_q == TIMER_LAST);

`ifdef ARP_CACHE_EN
    logic        cache_vld_q;
    logic [31:0] cache_ip_q;
    logic [47:0] cache_mac_q;

    assign cache_hit = cache_vld_q && (cache_ip_q == req_ip);
    assign cache_mac = cache_mac_q;

    // Learn from every reply addressed to us; a successful resolution is such a reply, so it is covered too
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cache_vld_q <= 1'b0;
            cache_ip_q  <= '0;
            cache_mac_q <= '0;
        end else if (rx_done && (rx_tpa == IP_ADDR)) begin
            cache_vld_q <= 1'b1;
            cache_ip_q  <= rx_spa;
            cache_mac_q <= rx_sha;
        end
    end
`else
    assign cache_hit = 1'b0;
    assign cache_mac = 48'h0;
`endif

    // Payload byte selected by the current index: fixed ARP header, our addresses, blank THA, target IP
    always_comb begin
        payload_byte = 8'h00;
        case (idx_q)
            5'd0:  payload_byte = 8'h00;
            5'd1:  payload_byte = 8'h01;
            5'd2:  payload_byte = 8'h08;
            5'd3:  payload_byte = 8'h00;
            5'd4:  payload_byte = 8'h06;
            5'd5:  payload_byte = 8'h04;
            5'd6:  payload_byte = 8'h00;
            5'd7:  payload_byte = 8'h01;
            5'd8:  payload_byte = MAC_ADDR[47:40];
            5'd9:  payload_byte = MAC_ADDR[39:32];
            5'd10: payload_byte = MAC_ADDR[31:24];
            5'd11: payload_byte = MAC_ADDR[23:16];
            5'd12: payload_byte = MAC_ADDR[15:8];
            5'd13: payload_byte = MAC_ADDR[7:0];
            5'd14: payload_byte = IP_ADDR[31:24];
            5'd15: payload_byte = IP_ADDR[23:16];
            5'd16: payload_byte = IP_ADDR[15:8];
            5'd17: payload_byte = IP_ADDR[7:0];
            5'd24: payload_byte = target_q[31:24];
            5'd25: payload_byte = target_q[23:16];
            5'd26: payload_byte = target_q[15:8];
            5'd27: payload_byte = target_q[7:0];
            default: payload_byte = 8'h00;
        endcase
    end

    // Request / transmit / wait-for-reply sequencing with retransmission on timeout
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            target_q    <= '0;
            timer_q     <= '0;
            retry_q     <= '0;
            idx_q       <= '0;
            tx_en_q     <= 1'b0;
            res_valid_q <= 1'b0;
            res_err_q   <= 1'b0;
            res_mac_q   <= '0;
        end else begin
            res_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        if (cache_hit) begin
                            res_valid_q <= 1'b1;
                            res_mac_q   <= cache_mac;
                            res_err_q   <= 1'b0;
                        end else begin
                            target_q <= req_ip;
                            retry_q  <= '0;
                            idx_q    <= '0;
                            tx_en_q  <= 1'b1;
                            state_q  <= ST_SEND;
                        end
                    end
                end
                ST_SEND: begin
                    if (tx_accept) begin
                        if (idx_q == 5'd27) begin
                            tx_en_q <= 1'b0;
                            timer_q <= '0;
                            state_q <= ST_WAIT;
                        end else begin
                            idx_q <= idx_q + 5'd1;
                        end
                    end
                end
                ST_WAIT: begin
                    timer_q <= timer_q + TIMER_W'(1);
                    if (rx_match) begin
                        res_valid_q <= 1'b1;
                        res_mac_q   <= rx_sha;
                        res_err_q   <= 1'b0;
                        state_q     <= ST_IDLE;
                    end else if (timer_expired) begin
                        if (retry_q < RETRY_MAX) begin
                            retry_q <= retry_q + RETRY_W'(1);
                            idx_q   <= '0;
                            tx_en_q <= 1'b1;
                            state_q <= ST_SEND;
                        end else begin
                            res_valid_q <= 1'b1;
                            res_mac_q   <= '0;
                            res_err_q   <= 1'b1;
                            state_q     <= ST_IDLE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
